seq_serializer: RTL and testbench



---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_shift_reg.sv | 45 ++++
 rtl/seq_serializer.sv | 66 ++++++
 tb/tb_seq_serializer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial symbol stream blocks.
package seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } seq_state_t;

    localparam logic SYM_A = 1'b0;
    localparam logic SYM_B = 1'b1;

    // Bits needed to represent values 0 .. v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Load/shift register with a down-counter; the current symbol is word[cnt-1].
module seq_shift_reg
    import seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_word,
    input  logic [LEN_W-1:0] load_len,
    output logic             sym,
    output logic             cnt_one,
    output logic             cnt_zero
);

    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= load_word;
            cnt   <= load_len;
        end else if (shift && cnt != '0) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    // Mux by count rather than shifting the data, so the word stays put.
    always_comb begin
        sym = SYM_A;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt == LEN_W'(i + 1)) sym = shreg[i];
        end
    end

    assign cnt_one  = (cnt == LEN_W'(1));
    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial symbol transmitter, MSB-first, gapless back-to-back words.
module seq_serializer
    import seq_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int LEN_W = clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_word,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             out_last
);

    seq_state_t       state, state_next;
    logic [LEN_W-1:0] len_clamped;
    logic             accept;
    logic             sym, cnt_one, cnt_zero;
    logic             sending;

    assign len_clamped = (in_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : in_len;
    assign sending     = (state == SEND);

    // Ready depends only on registered state, never on in_valid.
    assign in_ready = !sending || cnt_one;
    assign accept   = in_valid && in_ready;

    seq_shift_reg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shift (
        .clock     (clock),
        .reset     (reset),
        .load      (accept),
        .shift     (sending),
        .load_word (in_word),
        .load_len  (len_clamped),
        .sym       (sym),
        .cnt_one   (cnt_one),
        .cnt_zero  (cnt_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && len_clamped != '0) state_next = SEND;
            SEND: if (cnt_one) state_next = (accept && len_clamped != '0) ? SEND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode registered state only, so async reset clears them at once.
    assign out_valid = sending && !cnt_zero;
    assign out       = out_valid ? sym : SYM_A;
    assign out_last  = out_valid && cnt_one;

endmodule

// File: tb/tb_seq_serializer.sv
// Randomized and directed bench for seq_serializer against a symbol-queue model.
module tb_seq_serializer;
    import seq_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] in_word;
    logic [2:0] in_len;
    logic       in_valid;
    logic       in_ready, out, out_valid, out_last;

    logic [7:0] in_word8;
    logic [3:0] in_len8;
    logic       in_valid8;
    logic       in_ready8, out8, out_valid8, out_last8;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic sym;
        logic last;
    } exp_sym_t;
    exp_sym_t q[$];

    always #5 clock = ~clock;

    seq_serializer #(.WIDTH(4)) dut (
        .clock(clock), .reset(reset), .in_word(in_word), .in_len(in_len),
        .in_valid(in_valid), .in_ready(in_ready), .out(out),
        .out_valid(out_valid), .out_last(out_last)
    );

    seq_serializer #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .in_word(in_word8), .in_len(in_len8),
        .in_valid(in_valid8), .in_ready(in_ready8), .out(out8),
        .out_valid(out_valid8), .out_last(out_last8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // The head of the queue is the symbol on the line; the producer may hand
    // over a new word whenever at most one symbol remains.
    task automatic check_outs(input string tag);
        logic ev, eo, el;
        ev = (q.size() != 0);
        eo = ev ? q[0].sym : 1'b0;
        el = ev ? q[0].last : 1'b0;
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ":out"}, 32'(out), 32'(eo));
        chk({tag, ":out_last"}, 32'(out_last), 32'(el));
        chk({tag, ":in_ready"}, 32'(in_ready), 32'(q.size() <= 1));
    endtask

    task automatic cycle(input logic v, input logic [3:0] w, input logic [2:0] l, input string tag);
        logic acc;
        int   n;
        @(negedge clock);
        check_outs(tag);
        in_valid = v;
        in_word  = w;
        in_len   = l;
        @(posedge clock);
        acc = v && (q.size() <= 1);
        if (q.size() != 0) void'(q.pop_front());
        if (acc) begin
            n = (l > 3'd4) ? 4 : int'(l);
            for (int i = n - 1; i >= 0; i--) q.push_back('{sym: w[i], last: (i == 0)});
        end
    endtask

    initial begin
        logic s[7];
        logic det;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        in_len    = '0;
        in_valid8 = 1'b0;
        in_word8  = '0;
        in_len8   = '0;
        #1;
        chk("rst0:out", 32'(out), 0);
        chk("rst0:out_valid", 32'(out_valid), 0);
        chk("rst0:out_last", 32'(out_last), 0);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("rst0:in_ready", 32'(in_ready), 1);

        // abab single word
        cycle(1, 4'b0101, 3'd4, "abab");
        repeat (5) cycle(0, 4'h0, 3'd0, "abab");

        // back-to-back: next word presented during the last symbol
        cycle(1, 4'b0101, 3'd4, "b2b");
        repeat (3) cycle(0, 4'h0, 3'd0, "b2b");
        cycle(1, 4'b0011, 3'd2, "b2b");
        repeat (4) cycle(0, 4'h0, 3'd0, "b2b");

        // length edges
        cycle(1, 4'b1111, 3'd0, "len0");
        repeat (2) cycle(0, 4'h0, 3'd0, "len0");
        cycle(1, 4'b1100, 3'd7, "clamp");
        repeat (5) cycle(0, 4'h0, 3'd0, "clamp");

        // busy: in_valid held with changing word, ignored until the last symbol
        cycle(1, 4'b0101, 3'd4, "busy");
        repeat (3) cycle(1, 4'($urandom), 3'($urandom), "busy");
        repeat (6) cycle(0, 4'h0, 3'd0, "busy");

        // abort after 2 of 4 symbols
        cycle(1, 4'b0110, 3'd4, "abort");
        cycle(0, 4'h0, 3'd0, "abort");
        cycle(0, 4'h0, 3'd0, "abort");
        #2 reset = 1'b1;
        #1;
        chk("abort:out", 32'(out), 0);
        chk("abort:out_valid", 32'(out_valid), 0);
        chk("abort:out_last", 32'(out_last), 0);
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        #1 chk("abort:in_ready", 32'(in_ready), 1);
        cycle(1, 4'b1001, 3'd4, "restart");
        repeat (5) cycle(0, 4'h0, 3'd0, "restart");

        // random traffic
        repeat (400) cycle(logic'($urandom_range(0, 9) < 7), 4'($urandom), 3'($urandom), "rnd");
        repeat (6) cycle(0, 4'h0, 3'd0, "drain");

        // loopback "abaabab" into an abab detector sampled on the same clock
        @(negedge clock);
        in_valid8 = 1'b1;
        in_word8  = 8'b0100101;
        in_len8   = 4'd7;
        @(negedge clock);
        in_valid8 = 1'b0;
        in_word8  = 8'hff;
        for (int k = 0; k < 7; k++) begin
            s[k] = out8;
            chk("loop:out_valid", 32'(out_valid8), 1);
            chk("loop:out_last", 32'(out_last8), 32'(k == 6));
            det = (k >= 3) && s[k-3] == SYM_A && s[k-2] == SYM_B && s[k-1] == SYM_A && s[k] == SYM_B;
            chk("loop:det", 32'(det), 32'(k == 6));
            @(negedge clock);
        end
        chk("loop:sym", {25'd0, s[0], s[1], s[2], s[3], s[4], s[5], s[6]}, 32'b0100101);
        chk("loop:idle", 32'(out_valid8), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
